// File: rtl/reg_write_port_pkg.sv
// Shared constants, state encoding and decode helper for the register-bank write port.
package reg_write_port_pkg;

    localparam int NUM_REGS   = 32;
    localparam int ADDR_W     = 5;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    function automatic logic [NUM_REGS-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/reg_write_port_if.sv
// Valid/ready write-request channel into the register bank.
interface reg_write_port_if
    import reg_write_port_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);

endinterface

// File: rtl/reg_write_port_wr_fifo2.sv
// Two-entry synchronous FIFO; caller guarantees no push when full and no pop when empty.
module wr_fifo2 #(
    parameter int W = 37
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         head;
    logic         tail;

    // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= din;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign dout = mem[head];

endmodule

// File: rtl/reg_write_port.sv
// Write side of the 32-entry register bank: buffered writes, one-hot commit strobe, clear sweep.
module reg_write_port
    import reg_write_port_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    reg_write_port_if.slave           wr,
    input  logic                      clr_req,
    output logic [NUM_REGS-1:0]       wr_en_onehot,
    output logic                      busy,
    output logic [NUM_REGS*WIDTH-1:0] Q_flat
);

    localparam int ENTRY_W = ADDR_W + WIDTH;

    state_e             state;
    logic               clr_pend;
    logic [ADDR_W-1:0]  cnt;
    logic [WIDTH-1:0]   regs [NUM_REGS];

    logic [1:0]         fifo_count;
    logic [ENTRY_W-1:0] head_entry;
    logic [ADDR_W-1:0]  head_addr;
    logic [WIDTH-1:0]   head_data;
    logic               accept;
    logic               pop;

    assign wr.wr_ready = (fifo_count < 2'(FIFO_DEPTH)) && (state == IDLE) && !clr_pend;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign pop         = (state == IDLE) && (fifo_count != 2'd0);
    assign busy        = (fifo_count != 2'd0) || clr_pend || (state == CLEAR);
    assign {head_addr, head_data} = head_entry;

    wr_fifo2 #(.W(ENTRY_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept),
        .pop   (pop),
        .din   ({wr.wr_addr, wr.wr_data}),
        .dout  (head_entry),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            clr_pend     <= 1'b0;
            cnt          <= '0;
            wr_en_onehot <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            wr_en_onehot <= '0;
            case (state)
                IDLE: begin
                    if (clr_req) clr_pend <= 1'b1;
                    // Buffered writes always drain before a pending clear may start.
                    if (pop) begin
                        if (!(ZERO_REG != 0 && head_addr == '0)) begin
                            regs[head_addr] <= head_data;
                            wr_en_onehot    <= onehot(head_addr);
                        end
                    end else if (clr_pend) begin
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    regs[cnt]    <= '0;
                    wr_en_onehot <= onehot(cnt);
                    cnt          <= cnt + 1'b1;
                    if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                        clr_pend <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign Q_flat[g*WIDTH +: WIDTH] = regs[g];
    end

endmodule

// File: tb/tb_reg_write_port.sv
// Directed bench for reg_write_port: vector table for single-cycle behaviour plus clear/reset sequences.
module tb_reg_write_port;
    import reg_write_port_pkg::*;

    localparam int WIDTH = 32;

    logic                      clk;
    logic                      rst_n;
    logic                      clr_req;
    logic [NUM_REGS-1:0]       wr_en_onehot;
    logic                      busy;
    logic [NUM_REGS*WIDTH-1:0] q_flat;

    int checks   = 0;
    int failures = 0;

    reg_write_port_if #(.WIDTH(WIDTH)) wr_bus ();

    reg_write_port #(.WIDTH(WIDTH), .ZERO_REG(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr_bus.slave),
        .clr_req      (clr_req),
        .wr_en_onehot (wr_en_onehot),
        .busy         (busy),
        .Q_flat       (q_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        exp_ready;
        logic        exp_busy;
        logic [31:0] exp_onehot;
        int          reg_idx;
        logic [31:0] exp_reg;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return q_flat[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [31:0] bit_of(input int i);
        logic [31:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Holds the request until accepted, bounded; returns at the negedge after the accepting edge.
    task automatic do_write(input logic [4:0] addr, input logic [31:0] data, input logic clr);
        bit done = 0;
        wr_bus.wr_valid = 1'b1;
        wr_bus.wr_addr  = addr;
        wr_bus.wr_data  = data;
        clr_req         = clr;
        for (int i = 0; i < 20 && !done; i++) begin
            done = (wr_bus.wr_ready === 1'b1);
            @(negedge clk);
            clr_req = 1'b0;
        end
        if (!done) check("write_accept_timeout", 64'd0, 64'd1);
        wr_bus.wr_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h0000_0000, 5, 32'h0};
        vecs[1] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0000_0020, 5, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 5, 32'hDEADBEEF};
        vecs[3] = '{1'b1, 5'd1, 32'd11,       1'b1, 1'b1, 32'h0000_0000, 1, 32'h0};
        vecs[4] = '{1'b1, 5'd2, 32'd22,       1'b1, 1'b1, 32'h0000_0002, 1, 32'd11};
        vecs[5] = '{1'b1, 5'd3, 32'd33,       1'b1, 1'b1, 32'h0000_0004, 2, 32'd22};
        vecs[6] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0000_0008, 3, 32'd33};
        vecs[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 5, 32'hDEADBEEF};
        vecs[8] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0000_0000, 0, 32'h0};
        vecs[9] = '{1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 32'h0000_0000, 0, 32'h0};

        rst_n           = 1'b0;
        clr_req         = 1'b0;
        wr_bus.wr_valid = 1'b0;
        wr_bus.wr_addr  = '0;
        wr_bus.wr_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_qflat_zero", 64'(q_flat == '0), 64'd1);
        check("rst_ready",      64'(wr_bus.wr_ready), 64'd1);
        check("rst_busy",       64'(busy), 64'd0);
        check("rst_onehot",     64'(wr_en_onehot), 64'd0);

        for (int v = 0; v < 10; v++) begin
            wr_bus.wr_valid = vecs[v].valid;
            wr_bus.wr_addr  = vecs[v].addr;
            wr_bus.wr_data  = vecs[v].data;
            @(negedge clk);
            check($sformatf("vec%0d_ready", v),  64'(wr_bus.wr_ready), 64'(vecs[v].exp_ready));
            check($sformatf("vec%0d_busy", v),   64'(busy), 64'(vecs[v].exp_busy));
            check($sformatf("vec%0d_onehot", v), 64'(wr_en_onehot), 64'(vecs[v].exp_onehot));
            check($sformatf("vec%0d_reg%0d", v, vecs[v].reg_idx), 64'(reg_of(vecs[v].reg_idx)), 64'(vecs[v].exp_reg));
        end
        wr_bus.wr_valid = 1'b0;

        // Back-to-back writes to 20..31; the last one arrives together with clr_req.
        for (int i = 20; i < 31; i++) begin
            do_write(5'(i), 32'h100 + 32'(i), 1'b0);
        end
        do_write(5'd31, 32'h100 + 32'd31, 1'b1);
        check("clr_same_edge_ready", 64'(wr_bus.wr_ready), 64'd0);
        check("clr_same_edge_busy",  64'(busy), 64'd1);
        check("clr_reg30",           64'(reg_of(30)), 64'h11E);
        check("clr_onehot30",        64'(wr_en_onehot), 64'(bit_of(30)));
        @(negedge clk);
        check("drain_reg31",    64'(reg_of(31)), 64'h11F);
        check("drain_onehot31", 64'(wr_en_onehot), 64'(bit_of(31)));
        check("drain_ready",    64'(wr_bus.wr_ready), 64'd0);
        @(negedge clk);
        check("enter_clear_onehot", 64'(wr_en_onehot), 64'd0);
        check("enter_clear_busy",   64'(busy), 64'd1);
        for (int k = 0; k < 32; k++) begin
            clr_req = (k == 5);
            @(negedge clk);
            check($sformatf("sweep%0d_onehot", k), 64'(wr_en_onehot), 64'(bit_of(k)));
            check($sformatf("sweep%0d_ready", k),  64'(wr_bus.wr_ready), 64'(k == 31));
            if (k < 31) check($sformatf("sweep%0d_busy", k), 64'(busy), 64'd1);
        end
        clr_req = 1'b0;
        check("sweep_done_qflat", 64'(q_flat == '0), 64'd1);
        check("sweep_done_busy",  64'(busy), 64'd0);
        @(negedge clk);
        check("after_sweep_onehot", 64'(wr_en_onehot), 64'd0);
        check("after_sweep_busy",   64'(busy), 64'd0);

        // Reset in the middle of a sweep at count 10.
        for (int i = 20; i < 32; i++) begin
            do_write(5'(i), 32'hA000_0000 + 32'(i), 1'b0);
        end
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("midsweep_onehot9", 64'(wr_en_onehot), 64'(bit_of(9)));
        check("midsweep_reg20",   64'(reg_of(20)), 64'hA000_0014);
        #2 rst_n = 1'b0;
        #1;
        check("abort_qflat_zero", 64'(q_flat == '0), 64'd1);
        check("abort_onehot",     64'(wr_en_onehot), 64'd0);
        check("abort_busy",       64'(busy), 64'd0);
        check("abort_ready",      64'(wr_bus.wr_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_onehot", 64'(wr_en_onehot), 64'd0);
        check("post_rst_ready",  64'(wr_bus.wr_ready), 64'd1);
        do_write(5'd7, 32'd77, 1'b0);
        check("post_rst_reg7_early", 64'(reg_of(7)), 64'd0);
        check("post_rst_busy",       64'(busy), 64'd1);
        @(negedge clk);
        check("post_rst_reg7",    64'(reg_of(7)), 64'd77);
        check("post_rst_onehot7", 64'(wr_en_onehot), 64'h80);
        @(negedge clk);
        check("post_rst_strobe_end", 64'(wr_en_onehot), 64'd0);
        check("post_rst_idle_busy",  64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
